// File: rtl/shifter_barrel_pipe.sv
// -----------------------------------------------------------------------------
// shifter_barrel_pipe
//
// Pipelined barrel shifter with valid/ready handshakes on both sides.
// Supports pass, logical shift right/left, arithmetic shift right and rotate
// right/left.  Each of the N = $clog2(WIDTH) pipeline stages applies one
// power-of-two shift step.  Every result carries a carry bit (last bit shifted
// or wrapped out), a range flag and an error flag for reserved modes.
//
// Parameters
//   WIDTH          data width, power of two, >= 4
//   TAG_W          sideband tag width, >= 1
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_rst          synchronous active-high reset
//   i_valid        input beat valid
//   o_ready        input beat accepted when i_valid && o_ready at the edge
//   i_data         operand
//   i_ctrl         mode: 000 pass, 001 LSR, 010 ASR, 011 ROR, 100 LSL,
//                  110 ROL, 101/111 reserved (pass with o_err = 1)
//   i_shift_amount shift count, 0 .. 2*WIDTH-1
//   i_tag          sideband returned unchanged with the result
//   o_valid        result valid
//   i_ready        downstream accepts the result when o_valid && i_ready
//   o_data         result
//   o_carry        last bit shifted or wrapped out
//   o_range        shift amount >= WIDTH in a shift (non-rotate, non-pass) mode
//   o_err          mode was reserved
//   o_tag          tag of this result
// -----------------------------------------------------------------------------
module shifter_barrel_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    localparam int N  = $clog2(WIDTH),
    localparam int SW = N + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [2:0]       i_ctrl,
    input  logic [SW-1:0]    i_shift_amount,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry,
    output logic             o_range,
    output logic             o_err,
    output logic [TAG_W-1:0] o_tag
);

    typedef enum logic [2:0] {
        MODE_PASS = 3'b000,
        MODE_LSR  = 3'b001,
        MODE_ASR  = 3'b010,
        MODE_ROR  = 3'b011,
        MODE_LSL  = 3'b100,
        MODE_RSV5 = 3'b101,
        MODE_ROL  = 3'b110,
        MODE_RSV7 = 3'b111
    } mode_e;

    // Everything a beat needs besides its data word.  The remaining shift
    // amount, direction and fill are consumed stage by stage; carry, range,
    // error and tag are final at the input and simply ride along.
    typedef struct packed {
        logic [N-1:0]     amt;
        logic             left;
        logic             rot;
        logic             fill;
        logic             carry;
        logic             rng;
        logic             err;
        logic [TAG_W-1:0] tag;
    } meta_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [N-1:0]     stg_valid;
    logic [WIDTH-1:0] stg_data [N];
    meta_t            stg_meta [N];

    logic [N-1:0]     load;
    logic [N-1:0]     src_valid;
    logic [WIDTH-1:0] src_data [N];
    meta_t            src_meta [N];
    logic [WIDTH-1:0] nxt_data [N];
    meta_t            nxt_meta [N];

    logic [WIDTH-1:0] in_data;
    meta_t            in_meta;

    // A stage can load when it, or any stage below it towards the output,
    // has a free slot, or when the output is being drained.  Walking down
    // from the output keeps this a simple AND chain of valid bits.
    always_comb begin
        logic full_below;
        full_below = 1'b1;
        load       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            full_below = full_below & stg_valid[k];
            load[k]    = i_ready | ~full_below;
        end
    end

    assign o_ready = load[0] & ~i_rst;

    // Input decode.  Out-of-range plain shifts are resolved here by replacing
    // the operand with its fully shifted value (all zeros or all sign bits) and
    // a zero remaining amount, so the stages only ever see amounts < WIDTH.
    // Carry is picked straight from the operand: a right move by r exposes bit
    // r-1 last, a left move by r exposes bit WIDTH-r, which is -r modulo WIDTH.
    always_comb begin
        logic [N-1:0] r;
        logic [N-1:0] r_dec;
        logic [N-1:0] r_neg;
        logic         over;
        logic         s_nz;
        logic         s_is_w;

        r      = i_shift_amount[N-1:0];
        over   = i_shift_amount[N];
        s_nz   = |i_shift_amount;
        s_is_w = over & (r == '0);
        r_dec  = r - N'(1);
        r_neg  = N'(0) - r;

        in_data     = i_data;
        in_meta     = '0;
        in_meta.tag = i_tag;

        case (mode_e'(i_ctrl))
            MODE_LSR: begin
                in_meta.rng = over;
                if (over) begin
                    in_data       = '0;
                    in_meta.carry = s_is_w & i_data[WIDTH-1];
                end else begin
                    in_meta.amt   = r;
                    in_meta.carry = s_nz & i_data[r_dec];
                end
            end
            MODE_ASR: begin
                in_meta.rng  = over;
                in_meta.fill = i_data[WIDTH-1];
                if (over) begin
                    in_data       = {WIDTH{i_data[WIDTH-1]}};
                    in_meta.carry = i_data[WIDTH-1];
                end else begin
                    in_meta.amt   = r;
                    in_meta.carry = s_nz & i_data[r_dec];
                end
            end
            MODE_LSL: begin
                in_meta.rng  = over;
                in_meta.left = 1'b1;
                if (over) begin
                    in_data       = '0;
                    in_meta.carry = s_is_w & i_data[0];
                end else begin
                    in_meta.amt   = r;
                    in_meta.carry = s_nz & i_data[r_neg];
                end
            end
            MODE_ROR: begin
                in_meta.rot   = 1'b1;
                in_meta.amt   = r;
                in_meta.carry = (|r) & i_data[r_dec];
            end
            MODE_ROL: begin
                in_meta.rot   = 1'b1;
                in_meta.left  = 1'b1;
                in_meta.amt   = r;
                in_meta.carry = (|r) & i_data[r_neg];
            end
            MODE_RSV5, MODE_RSV7: begin
                in_meta.err = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Shift network.  Stage k takes the previous stage register (or the
    // decoded input for stage 0) and moves it by 2^k when bit k of the
    // remaining amount is set.
    always_comb begin
        src_valid[0] = i_valid;
        src_data[0]  = in_data;
        src_meta[0]  = in_meta;
        for (int k = 1; k < N; k++) begin
            src_valid[k] = stg_valid[k-1];
            src_data[k]  = stg_data[k-1];
            src_meta[k]  = stg_meta[k-1];
        end

        for (int k = 0; k < N; k++) begin
            nxt_meta[k] = src_meta[k];
            nxt_data[k] = src_data[k];
            if (src_meta[k].amt[k]) begin
                if (src_meta[k].left) begin
                    nxt_data[k] = src_meta[k].rot
                        ? (src_data[k] << (1 << k)) | (src_data[k] >> (WIDTH - (1 << k)))
                        : (src_data[k] << (1 << k));
                end else begin
                    nxt_data[k] = src_meta[k].rot
                        ? (src_data[k] >> (1 << k)) | (src_data[k] << (WIDTH - (1 << k)))
                        : (src_data[k] >> (1 << k)) |
                          (src_meta[k].fill ? ~(ALL_ONES >> (1 << k)) : '0);
                end
            end
        end
    end

    // Pipeline registers.  A loading stage always takes the upstream valid
    // bit, but only overwrites its payload when a real beat arrives, so the
    // outputs keep the last result rather than bubble contents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stg_valid <= '0;
            for (int k = 0; k < N; k++) begin
                stg_data[k] <= '0;
                stg_meta[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load[k]) begin
                    stg_valid[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        stg_data[k] <= nxt_data[k];
                        stg_meta[k] <= nxt_meta[k];
                    end
                end
            end
        end
    end

    assign o_valid = stg_valid[N-1];
    assign o_data  = stg_data[N-1];
    assign o_carry = stg_meta[N-1].carry;
    assign o_range = stg_meta[N-1].rng;
    assign o_err   = stg_meta[N-1].err;
    assign o_tag   = stg_meta[N-1].tag;

endmodule

// File: tb/tb_shifter_barrel_pipe.sv
// -----------------------------------------------------------------------------
// tb_shifter_barrel_pipe
//
// Self-checking bench for shifter_barrel_pipe at WIDTH=8, TAG_W=4.  A
// behavioural reference computes every result from the shift rules with plain
// arithmetic; a scoreboard queue tracks beats in flight and a negedge monitor
// compares ready, valid, payload and stall stability on every cycle.  Directed
// vectors with hand-computed results pin the reference itself.
// -----------------------------------------------------------------------------
module tb_shifter_barrel_pipe;

    localparam int W  = 8;
    localparam int TW = 4;
    localparam int N  = 3;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  i_data;
    logic [2:0]    i_ctrl;
    logic [SW-1:0] i_shift_amount;
    logic [TW-1:0] i_tag;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_data;
    logic          o_carry;
    logic          o_range;
    logic          o_err;
    logic [TW-1:0] o_tag;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int emitted = 0;
    bit stall_seen = 1'b0;

    typedef struct packed {
        logic [W-1:0] data;
        logic         carry;
        logic         rng;
        logic         err;
    } res_t;

    typedef struct {
        res_t          res;
        logic [TW-1:0] tag;
        int            acc;
    } beat_t;

    typedef struct packed {
        logic [2:0]    ctrl;
        logic [W-1:0]  data;
        logic [SW-1:0] s;
        logic [TW-1:0] tag;
        logic [W-1:0]  edata;
        logic          ecarry;
        logic          erange;
        logic          eerr;
    } vec_t;

    beat_t q[$];
    logic        held = 1'b0;
    logic [14:0] held_bits = '0;
    vec_t        vecs [16];

    shifter_barrel_pipe #(
        .WIDTH(W),
        .TAG_W(TW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_data         (i_data),
        .i_ctrl         (i_ctrl),
        .i_shift_amount (i_shift_amount),
        .i_tag          (i_tag),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_carry        (o_carry),
        .o_range        (o_range),
        .o_err          (o_err),
        .o_tag          (o_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference result straight from the shift rules.
    function automatic res_t model(input logic [2:0] ctrl, input logic [W-1:0] d, input int s);
        res_t           res;
        int             r;
        logic [2*W-1:0] dd;
        r         = s % W;
        dd        = {d, d};
        res.data  = d;
        res.carry = 1'b0;
        res.rng   = 1'b0;
        res.err   = 1'b0;
        case (ctrl)
            3'b001: begin
                res.rng   = (s >= W);
                res.data  = (s >= W) ? '0 : (d >> s);
                res.carry = (s >= 1 && s <= W) ? d[s-1] : 1'b0;
            end
            3'b010: begin
                res.rng   = (s >= W);
                res.data  = (s >= W) ? {W{d[W-1]}} : W'($signed(d) >>> s);
                res.carry = (s == 0) ? 1'b0 : ((s <= W) ? d[s-1] : d[W-1]);
            end
            3'b100: begin
                res.rng   = (s >= W);
                res.data  = (s >= W) ? '0 : W'(d << s);
                res.carry = (s >= 1 && s <= W) ? d[W-s] : 1'b0;
            end
            3'b011: begin
                dd        = dd >> r;
                res.data  = dd[W-1:0];
                res.carry = (r != 0) ? res.data[W-1] : 1'b0;
            end
            3'b110: begin
                dd        = dd << r;
                res.data  = dd[2*W-1:W];
                res.carry = (r != 0) ? res.data[0] : 1'b0;
            end
            3'b101, 3'b111: res.err = 1'b1;
            default: ;
        endcase
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Drive one beat and hold it until the DUT takes it (bounded).
    task automatic applyStimulus(input logic [2:0] ctrl, input logic [W-1:0] d,
                                 input logic [SW-1:0] s, input logic [TW-1:0] tag);
        bit ok;
        bit acc;
        ok             = 1'b0;
        i_valid        = 1'b1;
        i_ctrl         = ctrl;
        i_data         = d;
        i_shift_amount = s;
        i_tag          = tag;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!o_ready) stall_seen = 1'b1;
            acc = o_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("accept_timeout", 32'(ok), 32'd1);
    endtask

    // Count negedges after an accepting edge until o_valid (bounded).
    task automatic waitValid(output int cnt);
        int n;
        for (n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (o_valid) break;
        end
        cnt = n;
    endtask

    function automatic bit expValid();
        return (q.size() > 0) && (cyc >= q[0].acc + N);
    endfunction

    // Cycle-by-cycle compare against the scoreboard.  The oldest beat in
    // flight never waits behind anything, so it surfaces exactly N cycles
    // after acceptance; ready is low only when N beats are held and the
    // output is stalled, or during reset.
    always @(negedge clk) begin : monitor
        checkOutput("o_ready", 32'(o_ready), 32'(!i_rst && (i_ready || q.size() < N)));
        checkOutput("o_valid", 32'(o_valid), 32'(expValid()));
        if (held)
            checkOutput("stall_hold", 32'({o_data, o_carry, o_range, o_err, o_tag}), 32'(held_bits));
        if (o_valid && expValid()) begin
            checkOutput("o_data",  32'(o_data),  32'(q[0].res.data));
            checkOutput("o_carry", 32'(o_carry), 32'(q[0].res.carry));
            checkOutput("o_range", 32'(o_range), 32'(q[0].res.rng));
            checkOutput("o_err",   32'(o_err),   32'(q[0].res.err));
            checkOutput("o_tag",   32'(o_tag),   32'(q[0].tag));
        end
        if (i_rst) begin
            q.delete();
            held <= 1'b0;
        end else begin
            if (expValid() && i_ready) begin
                void'(q.pop_front());
                emitted <= emitted + 1;
            end
            held      <= o_valid && !i_ready;
            held_bits <= {o_data, o_carry, o_range, o_err, o_tag};
            if (i_valid && o_ready)
                q.push_back('{model(i_ctrl, i_data, int'(i_shift_amount)), i_tag, cyc});
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   lat;
        int   base;
        res_t r;

        vecs = '{
            '{3'b001, 8'hB4, 4'd3,  4'h5, 8'h16, 1'b1, 1'b0, 1'b0},
            '{3'b010, 8'hB4, 4'd9,  4'h1, 8'hFF, 1'b1, 1'b1, 1'b0},
            '{3'b010, 8'h34, 4'd0,  4'h2, 8'h34, 1'b0, 1'b0, 1'b0},
            '{3'b110, 8'h81, 4'd9,  4'h3, 8'h03, 1'b1, 1'b0, 1'b0},
            '{3'b011, 8'h01, 4'd1,  4'h4, 8'h80, 1'b1, 1'b0, 1'b0},
            '{3'b100, 8'h81, 4'd8,  4'h6, 8'h00, 1'b1, 1'b1, 1'b0},
            '{3'b101, 8'h5A, 4'd3,  4'h7, 8'h5A, 1'b0, 1'b0, 1'b1},
            '{3'b010, 8'hB4, 4'd3,  4'h8, 8'hF6, 1'b1, 1'b0, 1'b0},
            '{3'b001, 8'hB4, 4'd15, 4'h9, 8'h00, 1'b0, 1'b1, 1'b0},
            '{3'b100, 8'h81, 4'd1,  4'hA, 8'h02, 1'b1, 1'b0, 1'b0},
            '{3'b000, 8'hC3, 4'd5,  4'hB, 8'hC3, 1'b0, 1'b0, 1'b0},
            '{3'b011, 8'hB4, 4'd12, 4'hC, 8'h4B, 1'b0, 1'b0, 1'b0},
            '{3'b111, 8'h3C, 4'd0,  4'hD, 8'h3C, 1'b0, 1'b0, 1'b1},
            '{3'b010, 8'h34, 4'd12, 4'hE, 8'h00, 1'b0, 1'b1, 1'b0},
            '{3'b100, 8'h96, 4'd5,  4'hF, 8'hC0, 1'b0, 1'b0, 1'b0},
            '{3'b001, 8'h96, 4'd8,  4'h0, 8'h00, 1'b1, 1'b1, 1'b0}
        };

        i_rst          = 1'b1;
        i_valid        = 1'b0;
        i_ready        = 1'b1;
        i_data         = '0;
        i_ctrl         = '0;
        i_shift_amount = '0;
        i_tag          = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_o_valid", 32'(o_valid), 32'd0);
        checkOutput("reset_o_data",  32'(o_data),  32'd0);
        checkOutput("reset_flags",   32'({o_carry, o_range, o_err}), 32'd0);
        checkOutput("reset_o_tag",   32'(o_tag),   32'd0);
        checkOutput("reset_o_ready", 32'(o_ready), 32'd0);
        @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_release", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors, one at a time
        $display("[TB] directed vectors");
        for (int i = 0; i < 16; i++) begin
            r = model(vecs[i].ctrl, vecs[i].data, int'(vecs[i].s));
            checkOutput($sformatf("model_%0d", i), 32'(r),
                        32'({vecs[i].edata, vecs[i].ecarry, vecs[i].erange, vecs[i].eerr}));
            applyStimulus(vecs[i].ctrl, vecs[i].data, vecs[i].s, vecs[i].tag);
            i_valid = 1'b0;
            waitValid(lat);
            checkOutput($sformatf("latency_%0d", i), 32'(lat), 32'(N));
            checkOutput($sformatf("data_%0d", i),  32'(o_data),  32'(vecs[i].edata));
            checkOutput($sformatf("carry_%0d", i), 32'(o_carry), 32'(vecs[i].ecarry));
            checkOutput($sformatf("range_%0d", i), 32'(o_range), 32'(vecs[i].erange));
            checkOutput($sformatf("err_%0d", i),   32'(o_err),   32'(vecs[i].eerr));
            checkOutput($sformatf("tag_%0d", i),   32'(o_tag),   32'(vecs[i].tag));
            @(posedge clk);
            #1;
        end

        // Backpressure: six back-to-back beats, i_ready low for cycles 2-7
        $display("[TB] backpressure");
        stall_seen = 1'b0;
        base       = emitted;
        fork
            begin
                for (int t = 1; t <= 8; t++) begin
                    i_ready = !(t >= 2 && t <= 7);
                    @(posedge clk);
                    #1;
                end
                i_ready = 1'b1;
            end
            begin
                applyStimulus(vecs[0].ctrl,  vecs[0].data,  vecs[0].s,  4'h0);
                applyStimulus(vecs[1].ctrl,  vecs[1].data,  vecs[1].s,  4'h1);
                applyStimulus(vecs[3].ctrl,  vecs[3].data,  vecs[3].s,  4'h2);
                applyStimulus(vecs[4].ctrl,  vecs[4].data,  vecs[4].s,  4'h3);
                applyStimulus(vecs[7].ctrl,  vecs[7].data,  vecs[7].s,  4'h4);
                applyStimulus(vecs[14].ctrl, vecs[14].data, vecs[14].s, 4'h5);
                i_valid = 1'b0;
            end
        join
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) break;
        end
        checkOutput("bp_ready_drop", 32'(stall_seen), 32'd1);
        checkOutput("bp_count", 32'(emitted - base), 32'd6);

        // Reset with two beats in flight
        $display("[TB] reset mid-flight");
        base = emitted;
        applyStimulus(vecs[0].ctrl, vecs[0].data, vecs[0].s, 4'h1);
        applyStimulus(vecs[3].ctrl, vecs[3].data, vecs[3].s, 4'h2);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready_low", 32'(o_ready), 32'd0);
        checkOutput("rst_no_valid",  32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
        i_rst          = 1'b0;
        i_valid        = 1'b1;
        i_ctrl         = vecs[9].ctrl;
        i_data         = vecs[9].data;
        i_shift_amount = vecs[9].s;
        i_tag          = 4'hA;
        @(negedge clk);
        checkOutput("rst_o_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_o_data",  32'(o_data),  32'd0);
        checkOutput("rst_flags",   32'({o_carry, o_range, o_err}), 32'd0);
        checkOutput("rst_o_tag",   32'(o_tag),   32'd0);
        checkOutput("rst_ready_release", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1 i_valid = 1'b0;
        waitValid(lat);
        checkOutput("rst_new_latency", 32'(lat), 32'(N));
        checkOutput("rst_new_data", 32'(o_data), 32'h02);
        checkOutput("rst_new_tag",  32'(o_tag),  32'hA);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("rst_count", 32'(emitted - base), 32'd1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
